// File: rtl/ifmaps_feeder.sv
// ifmaps_feeder: turns a stream of ifmap rows into a sliding window of k
// consecutive rows (k = clamped kernel_size, 1..5) for a MAC array.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : frame start pulse (honoured only in IDLE)
//   kernel_size         : window height, 0 or >5 means 5
//   row_total           : rows N in the frame
//   row_in/_valid/_ready: upstream row handshake, bit i = lane i
//   mac_ready           : MAC array consumes the presented window
//   ifmaps_from_fifo    : window, bit idx*5+r = row r (0 = oldest) of lane idx
//   ifmaps_input_valid  : window valid
//   load_ifmaps         : first window of the frame is being presented
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
module ifmaps_feeder #(
  parameter int MAC_NUM = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           kernel_size,
  input  logic [9:0]           row_total,
  input  logic [MAC_NUM-1:0]   row_in,
  input  logic                 row_in_valid,
  output logic                 row_in_ready,
  input  logic                 mac_ready,
  output logic [5*MAC_NUM-1:0] ifmaps_from_fifo,
  output logic                 ifmaps_input_valid,
  output logic                 load_ifmaps,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [9:0]         n_q, n_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [MAC_NUM-1:0] win_q [5];
  logic [MAC_NUM-1:0] win_d [5];
  logic               valid_q, valid_d;
  logic               load_q, load_d;
  logic               done_q, done_d;

  logic [2:0]         k_clamp;
  logic               xfer;
  logic [9:0]         cnt_inc;
  logic [9:0]         k_ext;
  logic [MAC_NUM-1:0] ext [6];
  logic [MAC_NUM-1:0] shifted [5];

  always_comb begin
    if (kernel_size == 5'd0 || kernel_size > 5'd5) k_clamp = 3'd5;
    else                                           k_clamp = kernel_size[2:0];
  end

  always_comb begin
    row_in_ready = 1'b0;
    case (state_q)
      FILL:    row_in_ready = 1'b1;
      STREAM:  row_in_ready = ~valid_q | mac_ready;
      default: row_in_ready = 1'b0;
    endcase
  end

  assign xfer    = row_in_valid & row_in_ready;
  assign cnt_inc = cnt_q + 10'd1;
  assign k_ext   = {7'd0, k_q};

  // Only rows 0..k-1 shift; row k-1 takes the new row. Rows >= k were
  // cleared at start and are never written, so they stay zero.
  always_comb begin
    for (int unsigned r = 0; r < 5; r++) ext[r] = win_q[r];
    ext[5] = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      if (r + 1 < 32'(k_q))       shifted[r] = ext[r+1];
      else if (r + 1 == 32'(k_q)) shifted[r] = row_in;
      else                        shifted[r] = win_q[r];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    valid_d = valid_q;
    load_d  = load_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (row_total < {7'd0, k_clamp}) begin
            done_d = 1'b1;
          end else begin
            k_d     = k_clamp;
            n_d     = row_total;
            cnt_d   = '0;
            win_d   = '{default: '0};
            valid_d = 1'b0;
            load_d  = 1'b0;
            state_d = (k_clamp == 3'd1) ? STREAM : FILL;
          end
        end
      end
      FILL: begin
        if (xfer) begin
          win_d = shifted;
          cnt_d = cnt_inc;
          if (cnt_inc == k_ext - 10'd1) state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          win_d   = shifted;
          cnt_d   = cnt_inc;
          valid_d = 1'b1;
          load_d  = (cnt_inc == k_ext);
          if (cnt_inc == n_q) state_d = DRAIN;
        end else if (mac_ready) begin
          valid_d = 1'b0;
          load_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (valid_q && mac_ready) begin
          valid_d = 1'b0;
          load_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ifmaps_from_fifo = '0;
    for (int unsigned idx = 0; idx < MAC_NUM; idx++)
      for (int unsigned r = 0; r < 5; r++)
        ifmaps_from_fifo[idx*5+r] = win_q[r][idx];
  end

  assign ifmaps_input_valid = valid_q;
  assign load_ifmaps        = load_q;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;

endmodule

// File: tb/tb_ifmaps_feeder.sv
module tb_ifmaps_feeder;
  localparam int MN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4:0]    kernel_size;
  logic [9:0]    row_total;
  logic [MN-1:0] row_in;
  logic          row_in_valid;
  logic          row_in_ready;
  logic          mac_ready;
  logic [5*MN-1:0] ifmaps_from_fifo;
  logic          ifmaps_input_valid;
  logic          load_ifmaps;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [MN-1:0]   rows [0:15];
  logic [5*MN-1:0] exp_q [$];
  bit              exp_load_q [$];

  ifmaps_feeder #(.MAC_NUM(MN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_size(kernel_size),
    .row_total(row_total), .row_in(row_in), .row_in_valid(row_in_valid),
    .row_in_ready(row_in_ready), .mac_ready(mac_ready),
    .ifmaps_from_fifo(ifmaps_from_fifo), .ifmaps_input_valid(ifmaps_input_valid),
    .load_ifmaps(load_ifmaps), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected windows for a frame, built from the row table.
  function automatic void push_exp(input int k_raw, input int n);
    int kc;
    logic [5*MN-1:0] e;
    logic [MN-1:0] rv;
    kc = (k_raw == 0 || k_raw > 5) ? 5 : k_raw;
    for (int w = 0; w <= n - kc; w++) begin
      e = '0;
      for (int r = 0; r < kc; r++) begin
        rv = rows[w+r];
        for (int idx = 0; idx < MN; idx++) e[idx*5+r] = rv[idx];
      end
      exp_q.push_back(e);
      exp_load_q.push_back(w == 0);
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({row_in_ready, ifmaps_input_valid, load_ifmaps, busy, done} !== 5'b0 ||
        ifmaps_from_fifo !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%b v=%b ld=%b busy=%b done=%b win=%h exp all 0", tag,
               row_in_ready, ifmaps_input_valid, load_ifmaps, busy, done, ifmaps_from_fifo);
    end
  endtask

  task automatic run_frame(input int k_raw, input int n, input int stall_at, input int stall_len,
                           output int nwin, output int first_c, output int last_c,
                           output int rdy_cnt, output bit saw_done);
    int cyc, ridx;
    bit fin, hold_v;
    logic [5*MN-1:0] hold_w, e;
    bit el;
    nwin = 0; first_c = -1; last_c = -1; rdy_cnt = 0; saw_done = 0;
    cyc = 0; ridx = 0; fin = 0; hold_v = 0; hold_w = '0;
    push_exp(k_raw, n);
    @(negedge clk);
    start = 1'b1; kernel_size = 5'(k_raw); row_total = 10'(n);
    while (!fin && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      kernel_size = 5'd2; row_total = 10'd1;  // mid-frame changes must be ignored
      if (done) begin
        saw_done = 1; fin = 1;
      end else begin
        mac_ready    = !(cyc >= stall_at && cyc < stall_at + stall_len);
        row_in_valid = (ridx < n);
        row_in       = (ridx < n) ? rows[ridx] : '0;
        #1;
        if (hold_v) begin
          checks++;
          if (ifmaps_input_valid !== 1'b1 || ifmaps_from_fifo !== hold_w) begin
            errors++;
            $display("FAIL stall_hold got v=%b win=%h exp v=1 win=%h",
                     ifmaps_input_valid, ifmaps_from_fifo, hold_w);
          end
        end
        hold_v = 0;
        if (ifmaps_input_valid && !mac_ready) begin
          hold_v = 1; hold_w = ifmaps_from_fifo;
          checks++;
          if (row_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready got %b exp 0", row_in_ready);
          end
        end
        if (row_in_ready) rdy_cnt++;
        if (ifmaps_input_valid && mac_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_window got %h exp none", ifmaps_from_fifo);
          end else begin
            e = exp_q.pop_front(); el = exp_load_q.pop_front();
            if (ifmaps_from_fifo !== e || load_ifmaps !== el) begin
              errors++;
              $display("FAIL window%0d got %h ld=%b exp %h ld=%b",
                       nwin, ifmaps_from_fifo, load_ifmaps, e, el);
            end
          end
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          nwin++;
        end
        if (row_in_ready && row_in_valid) ridx++;
        cyc++;
      end
    end
    row_in_valid = 1'b0; mac_ready = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL done_timeout got no done exp done within 300 cycles");
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width got done=%b busy=%b exp 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_windows got %0d left exp 0", exp_q.size());
    end
    exp_q.delete(); exp_load_q.delete();
  endtask

  task automatic check_count(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; kernel_size = 0; row_total = 0;
    row_in = '0; row_in_valid = 0; mac_ready = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_basic_k3();
    int nw, fc, lc, rc; bit sd;
    for (int i = 0; i < 5; i++) rows[i] = 4'(i + 1);
    run_frame(3, 5, 1000, 0, nw, fc, lc, rc, sd);
    check_count("k3_windows", nw, 3);
    check_count("k3_done", int'(sd), 1);
  endtask

  task automatic test_stall();
    int nw, fc, lc, rc; bit sd;
    for (int i = 0; i < 4; i++) rows[i] = 4'(i + 1);
    run_frame(3, 4, 3, 4, nw, fc, lc, rc, sd);
    check_count("stall_windows", nw, 2);
  endtask

  task automatic test_short_frame();
    int nw, fc, lc, rc; bit sd;
    run_frame(5, 3, 1000, 0, nw, fc, lc, rc, sd);
    check_count("short_windows", nw, 0);
    check_count("short_ready", rc, 0);
    check_count("short_done", int'(sd), 1);
  endtask

  task automatic test_k1();
    int nw, fc, lc, rc; bit sd;
    rows[0] = 4'hA; rows[1] = 4'hB;
    run_frame(1, 2, 1000, 0, nw, fc, lc, rc, sd);
    check_count("k1_windows", nw, 2);
  endtask

  task automatic test_k0_clamp();
    int nw, fc, lc, rc; bit sd;
    for (int i = 0; i < 5; i++) rows[i] = 4'(i + 1);
    run_frame(0, 5, 1000, 0, nw, fc, lc, rc, sd);
    check_count("k0_windows", nw, 1);
  endtask

  task automatic test_back_to_back();
    int nw, fc, lc, rc; bit sd;
    for (int i = 0; i < 10; i++) rows[i] = 4'($urandom_range(0, 15));
    run_frame(2, 10, 1000, 0, nw, fc, lc, rc, sd);
    check_count("b2b_windows", nw, 9);
    check_count("b2b_span", lc - fc, 8);
  endtask

  task automatic test_reset_mid_frame();
    bit seen_done;
    for (int i = 0; i < 5; i++) rows[i] = 4'(i + 1);
    @(negedge clk);
    start = 1; kernel_size = 5'd3; row_total = 10'd5;
    mac_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 0;
      row_in_valid = 1; row_in = rows[i];
    end
    checks++;
    if (ifmaps_input_valid !== 1'b1) begin
      errors++;
      $display("FAIL midframe_valid got %b exp 1", ifmaps_input_valid);
    end
    rst_n = 0; row_in_valid = 0;
    @(negedge clk);
    check_idle_outputs("reset_mid_stream");
    rst_n = 1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_count("no_done_after_abort", int'(seen_done), 0);
    test_basic_k3();
  endtask

  initial begin
    test_reset();
    test_basic_k3();
    test_stall();
    test_short_frame();
    test_k1();
    test_k0_clamp();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmaps_feeder.md
IFMAPS_FEEDER -- requirements
Module: ifmaps_feeder

Interface
REQ-001 SHALL have parameter MAC_NUM, default 256, number of MAC lanes driven.
REQ-002 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-005 SHALL have kernel_size  input  5  window height k, sampled on accepted start.
REQ-006 SHALL have row_total  input  10  input rows N in the frame, sampled on accepted start.
REQ-007 SHALL have row_in  input  MAC_NUM  one ifmap row, bit i for lane i.
REQ-008 SHALL have row_in_valid  input  1  upstream row available.
REQ-009 SHALL have row_in_ready  output  1  feeder accepts row_in this cycle.
REQ-010 SHALL have mac_ready  input  1  array consumes the presented window this cycle.
REQ-011 SHALL have ifmaps_from_fifo  output  5*MAC_NUM  window; bit idx*5+r = row r, lane idx.
REQ-012 SHALL have ifmaps_input_valid  output  1  window on ifmaps_from_fifo is valid.
REQ-013 SHALL have load_ifmaps  output  1  high while the first window of a frame is presented.
REQ-014 SHALL have busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement states IDLE, FILL, STREAM, DRAIN.
REQ-017 SHALL clamp kernel_size: values 0 or >5 use k=5; values 1..5 used as-is.
REQ-018 IDLE: start with N>=k -> FILL (or STREAM directly if k=1); start with N<k -> done pulse next cycle, stay IDLE.
REQ-019 Row transfer SHALL occur only when row_in_valid and row_in_ready are both high.
REQ-020 FILL: row_in_ready=1; each transfer shifts window (row r <= row r+1, row k-1 <= row_in); after k-1 transfers -> STREAM.
REQ-021 STREAM: row_in_ready = ~ifmaps_input_valid | mac_ready; transfer performs same shift and sets ifmaps_input_valid next cycle.
REQ-022 Window SHALL NOT change while ifmaps_input_valid=1 and mac_ready=0.
REQ-023 mac_ready with no same-cycle transfer SHALL clear ifmaps_input_valid next cycle.
REQ-024 Window rows r>=k SHALL read 0; row 0 is the oldest row.
REQ-025 Frame SHALL emit exactly N-k+1 windows; after the N-th transfer -> DRAIN.
REQ-026 DRAIN: row_in_ready=0; on mac_ready with valid high -> valid cleared, done pulse same edge, -> IDLE.
REQ-027 load_ifmaps SHALL be high exactly while the frame's first window is valid, low otherwise.
REQ-028 Latency: row_in transfer to ifmaps_input_valid high SHALL be 1 cycle.
REQ-029 start outside IDLE SHALL be ignored; kernel_size/row_total changes mid-frame ignored.
REQ-030 Row counter SHALL be 10 bits, compared against latched N; no wrap within a frame.
REQ-031 Full back-to-back throughput: row_in_valid and mac_ready held high SHALL yield one window per cycle.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, clear window, counters and latched k/N.
REQ-033 During/after reset: row_in_ready, ifmaps_input_valid, load_ifmaps, busy, done all 0; ifmaps_from_fifo all 0.
REQ-034 Reset mid-frame SHALL abort with no done pulse; next start after release behaves as first frame.

Verification (MAC_NUM=4)
REQ-035 k=3, N=5, rows 0x1..0x5, mac_ready=1 -> 3 windows: {1,2,3},{2,3,4},{3,4,5}; load_ifmaps on first only; done after third.
REQ-036 k=3, N=4, mac_ready low 4 cycles on window {1,2,3} -> window and valid held, row_in_ready=0, no row lost.
REQ-037 k=5, N=3 -> no window, row_in_ready never high, done pulse 1 cycle after start.
REQ-038 k=1, N=2, rows 0xA,0xB -> windows row0=0xA then 0xB, rows 1..4 = 0.
REQ-039 k=0 treated as 5, N=5 -> single window rows 1..5, done after mac_ready.
REQ-040 rst_n low during STREAM -> next edge all outputs 0, no done; new start runs REQ-035 correctly.
